// File: rtl/sv32_pkg.sv
// Shared SV32 MMU definitions: page geometry constants and the types used
// by the page-table-walker arbiter.
package sv32_pkg;

   localparam int SV32_PAGE_SHIFT = 12;
   localparam int SV32_VPN_BITS   = 10;
   localparam int SV32_LEVELS     = 2;
   localparam int SV32_PTE_BYTES  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } ptwarb_state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

endpackage

// File: rtl/sv32_ptw_arbiter.sv
// Shares one SV32 page-table walker between the instruction-fetch and the
// load/store translators; one walk in flight, completion pulsed to its owner.
module sv32_ptw_arbiter
   import sv32_pkg::*;
#(
   parameter int ROUND_ROBIN = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_walk_valid,
   input  logic [31:0] i_address,
   output logic        i_walk_ready,
   input  logic        d_walk_valid,
   input  logic [31:0] d_address,
   output logic        d_walk_ready,
   output logic [31:0] pte,
   output logic        ptw_valid,
   output logic [31:0] ptw_address,
   output logic        ptw_is_instr,
   input  logic        ptw_ready,
   input  logic [31:0] ptw_pte,
   output logic [1:0]  dbg_state_o
);

   // Handshake: a translator holds walk_valid until it sees its own one-cycle
   // walk_ready; the walker sees ptw_valid for the whole walk and answers with
   // a one-cycle ptw_ready that qualifies ptw_pte.

   ptwarb_state_t state_q, state_d;
   grant_t        grant_q, grant_d;
   grant_t        last_grant_q, last_grant_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   pte_q, pte_d;

   // On contention in round-robin mode the side not served last wins.
   function automatic grant_t pick_grant(input logic iv, input logic dv,
                                         input grant_t last);
      if (iv && dv)
         return (ROUND_ROBIN != 0 && last == GRANT_D) ? GRANT_I : GRANT_D;
      else if (iv)
         return GRANT_I;
      else
         return GRANT_D;
   endfunction

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         grant_q      <= GRANT_I;
         last_grant_q <= GRANT_I;
         addr_q       <= 32'h0;
         pte_q        <= 32'h0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         pte_q        <= pte_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      pte_d        = pte_q;
      case (state_q)
         IDLE: begin
            if (i_walk_valid || d_walk_valid) begin
               grant_d = pick_grant(i_walk_valid, d_walk_valid, last_grant_q);
               addr_d  = (grant_d == GRANT_I) ? i_address : d_address;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (ptw_ready) begin
               pte_d        = ptw_pte;
               last_grant_d = grant_q;
               state_d      = RESP;
            end
         end
         // RESP lasts one cycle so the served requester, whose walk_valid is
         // still high, cannot be re-granted on the same request.
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign ptw_valid    = (state_q == BUSY);
   assign ptw_address  = addr_q;
   assign ptw_is_instr = (state_q == BUSY) && (grant_q == GRANT_I);
   assign i_walk_ready = (state_q == RESP) && (grant_q == GRANT_I);
   assign d_walk_ready = (state_q == RESP) && (grant_q == GRANT_D);
   assign pte          = pte_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_sv32_ptw_arbiter.sv
// Directed bench for sv32_ptw_arbiter: a round-robin instance and a
// fixed-priority instance sharing clock and reset.
module tb_sv32_ptw_arbiter;
   import sv32_pkg::*;

   logic clk;
   logic resetn;

   // round-robin instance
   logic        i_v, d_v, i_rdy, d_rdy, p_valid, p_instr, p_ready;
   logic [31:0] i_addr, d_addr, p_pte_o, p_addr, p_pte_i;
   logic [1:0]  st;

   // fixed-priority instance
   logic        f_i_v, f_d_v, f_i_rdy, f_d_rdy, f_valid, f_instr, f_ready;
   logic [31:0] f_i_addr, f_d_addr, f_pte_o, f_addr, f_pte_i;
   logic [1:0]  f_st;

   int n_cmp = 0;
   int n_mis = 0;
   bit sel = 1'b0;

   logic        m_valid, m_instr, m_i_rdy, m_d_rdy;
   logic [31:0] m_addr, m_pte;
   logic [1:0]  m_st;

   sv32_ptw_arbiter #(.ROUND_ROBIN(1)) dut_rr (
      .clk(clk), .resetn(resetn),
      .i_walk_valid(i_v), .i_address(i_addr), .i_walk_ready(i_rdy),
      .d_walk_valid(d_v), .d_address(d_addr), .d_walk_ready(d_rdy),
      .pte(p_pte_o), .ptw_valid(p_valid), .ptw_address(p_addr),
      .ptw_is_instr(p_instr), .ptw_ready(p_ready), .ptw_pte(p_pte_i),
      .dbg_state_o(st)
   );

   sv32_ptw_arbiter #(.ROUND_ROBIN(0)) dut_fp (
      .clk(clk), .resetn(resetn),
      .i_walk_valid(f_i_v), .i_address(f_i_addr), .i_walk_ready(f_i_rdy),
      .d_walk_valid(f_d_v), .d_address(f_d_addr), .d_walk_ready(f_d_rdy),
      .pte(f_pte_o), .ptw_valid(f_valid), .ptw_address(f_addr),
      .ptw_is_instr(f_instr), .ptw_ready(f_ready), .ptw_pte(f_pte_i),
      .dbg_state_o(f_st)
   );

   assign m_valid = sel ? f_valid : p_valid;
   assign m_instr = sel ? f_instr : p_instr;
   assign m_i_rdy = sel ? f_i_rdy : i_rdy;
   assign m_d_rdy = sel ? f_d_rdy : d_rdy;
   assign m_addr  = sel ? f_addr  : p_addr;
   assign m_pte   = sel ? f_pte_o : p_pte_o;
   assign m_st    = sel ? f_st    : st;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_walker(input logic rdy, input logic [31:0] val);
      if (sel) begin
         f_ready = rdy;
         f_pte_i = val;
      end else begin
         p_ready = rdy;
         p_pte_i = val;
      end
   endtask

   // Call at an IDLE-cycle negedge with the request(s) already driven.
   // Walk lasts lat BUSY cycles, then one RESP cycle, then back to IDLE.
   task automatic walk(input string tag, input logic exp_i, input logic [31:0] exp_addr,
                       input logic [31:0] pte_v, input int lat);
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         chk({tag, ".busy_valid"}, {31'h0, m_valid}, 32'h1);
         chk({tag, ".busy_addr"}, m_addr, exp_addr);
         chk({tag, ".busy_instr"}, {31'h0, m_instr}, {31'h0, exp_i});
         if (c == lat) set_walker(1'b1, pte_v);
      end
      @(negedge clk);
      set_walker(1'b0, 32'h0);
      chk({tag, ".resp_i_rdy"}, {31'h0, m_i_rdy}, {31'h0, exp_i});
      chk({tag, ".resp_d_rdy"}, {31'h0, m_d_rdy}, {31'h0, ~exp_i});
      chk({tag, ".resp_pte"}, m_pte, pte_v);
      chk({tag, ".resp_valid"}, {31'h0, m_valid}, 32'h0);
      @(negedge clk);
      chk({tag, ".idle_rdy"}, {30'h0, m_i_rdy, m_d_rdy}, 32'h0);
      chk({tag, ".idle_valid"}, {31'h0, m_valid}, 32'h0);
      chk({tag, ".idle_pte"}, m_pte, pte_v);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".valid"}, {31'h0, m_valid}, 32'h0);
      chk({tag, ".instr"}, {31'h0, m_instr}, 32'h0);
      chk({tag, ".rdy"}, {30'h0, m_i_rdy, m_d_rdy}, 32'h0);
      chk({tag, ".addr"}, m_addr, 32'h0);
      chk({tag, ".pte"}, m_pte, 32'h0);
      chk({tag, ".state"}, {30'h0, m_st}, {30'h0, IDLE});
   endtask

   initial begin
      resetn = 1'b0;
      i_v = 0; d_v = 0; i_addr = 0; d_addr = 0; p_ready = 0; p_pte_i = 0;
      f_i_v = 0; f_d_v = 0; f_i_addr = 0; f_d_addr = 0; f_ready = 0; f_pte_i = 0;

      // reset values on both instances
      repeat (2) @(negedge clk);
      sel = 1'b0; #1 chk_reset_outputs("rst_rr");
      sel = 1'b1; #1 chk_reset_outputs("rst_fp");
      sel = 1'b0;
      resetn = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", {31'h0, p_valid}, 32'h0);

      // contention after reset: D, I, D, I
      i_v = 1; d_v = 1; i_addr = 32'h1000_0000; d_addr = 32'h2000_0000;
      walk("rr_c1_d", 1'b0, 32'h2000_0000, 32'hAAAA_0001, 1);
      walk("rr_c2_i", 1'b1, 32'h1000_0000, 32'hBBBB_0002, 1);
      walk("rr_c3_d", 1'b0, 32'h2000_0000, 32'hCCCC_0003, 2);
      walk("rr_c4_i", 1'b1, 32'h1000_0000, 32'hDDDD_0004, 1);
      i_v = 0; d_v = 0;
      @(negedge clk);
      chk("rr_c_quiet", {31'h0, p_valid}, 32'h0);

      // single instruction walk; valid held through RESP then dropped
      i_v = 1; i_addr = 32'h8000_1234;
      walk("single_i", 1'b1, 32'h8000_1234, 32'h2000_04CF, 2);
      i_v = 0;
      @(negedge clk);
      chk("stale_valid1", {31'h0, p_valid}, 32'h0);
      chk("stale_rdy1", {30'h0, i_rdy, d_rdy}, 32'h0);
      @(negedge clk);
      chk("stale_valid2", {31'h0, p_valid}, 32'h0);
      chk("stale_state", {30'h0, st}, {30'h0, IDLE});

      // walker completion while idle is ignored
      p_ready = 1; p_pte_i = 32'hDEAD_BEEF;
      @(negedge clk);
      p_ready = 0; p_pte_i = 0;
      chk("intf_state", {30'h0, st}, {30'h0, IDLE});
      chk("intf_rdy", {30'h0, i_rdy, d_rdy}, 32'h0);
      chk("intf_pte", p_pte_o, 32'h2000_04CF);
      @(negedge clk);
      chk("intf_state2", {30'h0, st}, {30'h0, IDLE});

      // data address changes and request abandoned mid-walk
      d_v = 1; d_addr = 32'h3000_0040;
      @(negedge clk);
      chk("intf_busy_addr", p_addr, 32'h3000_0040);
      d_addr = 32'h3FFF_F000; d_v = 0;
      walk("intf_d", 1'b0, 32'h3000_0040, 32'h1111_0005, 1);

      // reset while BUSY
      i_v = 1; i_addr = 32'h4000_0000;
      @(negedge clk);
      chk("mid_busy_valid", {31'h0, p_valid}, 32'h1);
      resetn = 1'b0; i_v = 0;
      #1 chk_reset_outputs("mid_rst");
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      i_v = 1; i_addr = 32'h5000_0000;
      walk("after_rst_i", 1'b1, 32'h5000_0000, 32'h2222_0006, 1);
      i_v = 0;

      // fixed priority: data wins every arbitration
      sel = 1'b1;
      f_i_v = 1; f_d_v = 1; f_i_addr = 32'h6000_0000; f_d_addr = 32'h7000_0000;
      walk("fp_1", 1'b0, 32'h7000_0000, 32'h3333_0007, 1);
      walk("fp_2", 1'b0, 32'h7000_0000, 32'h4444_0008, 1);
      walk("fp_3", 1'b0, 32'h7000_0000, 32'h5555_0009, 2);
      f_i_v = 0; f_d_v = 0;
      @(negedge clk);
      chk("fp_quiet", {31'h0, f_valid}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
